// File: rtl/ser_par_pkg.sv
// Shared definitions for the 8-bit serial link: comma character, byte width
// and the transmitter/receiver link state encoding.
package ser_par_pkg;

   localparam logic [7:0] COMMA_BC      = 8'hBC;
   localparam int         BITS_PER_BYTE = 8;

   typedef enum logic {
      SYNC   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/par_ser_tx.sv
// Parallel-to-serial transmitter: sends BC_MIN training commas after reset,
// then user bytes MSB first, filling every idle byte slot with a comma.
module par_ser_tx
   import ser_par_pkg::*;
#(
   parameter int unsigned BC_MIN = 4,
   parameter logic [7:0]  COMMA  = COMMA_BC
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       load_req,
   output logic       data_ack,
   output logic       data_out,
   output logic       active
);

   localparam int         CNT_W   = $clog2(BITS_PER_BYTE);
   localparam logic [3:0] BC_LAST = 4'(BC_MIN - 1);

   logic [CNT_W-1:0] bit_cnt;
   logic [7:0]       shreg;
   logic [3:0]       bc_cnt;
   logic [3:0]       bc_cnt_nxt;
   state_t           state;
   state_t           state_nxt;
   logic [7:0]       byte_sel;
   logic             load_edge;

   assign load_edge = (bit_cnt == CNT_W'(BITS_PER_BYTE - 1));

   // Outputs are forced low while reset is asserted, not just after the edge.
   assign load_req = reset & load_edge;
   assign active   = reset & (state == ACTIVE);
   assign data_ack = load_req & active & valid_in;

   always_comb begin
      state_nxt  = state;
      bc_cnt_nxt = bc_cnt;
      byte_sel   = COMMA;
      if (load_edge) begin
         case (state)
            SYNC: begin
               if (bc_cnt == BC_LAST) begin
                  state_nxt  = ACTIVE;
                  bc_cnt_nxt = 4'd0;
               end else begin
                  bc_cnt_nxt = bc_cnt + 4'd1;
               end
            end
            ACTIVE: begin
               if (valid_in) byte_sel = data_in;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_32f) begin
      if (!reset) begin
         bit_cnt  <= '1;
         shreg    <= 8'h00;
         data_out <= 1'b0;
         state    <= SYNC;
         bc_cnt   <= 4'd0;
      end else begin
         bit_cnt <= bit_cnt + 1'b1;
         state   <= state_nxt;
         bc_cnt  <= bc_cnt_nxt;
         // MSB goes straight to the line; the remaining 7 bits queue in shreg.
         if (load_edge) {data_out, shreg} <= {byte_sel, 1'b0};
         else           {data_out, shreg} <= {shreg, 1'b0};
      end
   end

endmodule

// File: tb/tb_par_ser_tx.sv
// Scoreboard bench for par_ser_tx: two instances (BC_MIN=4 and BC_MIN=1) share
// stimulus and are checked cycle by cycle against a byte-slot reference model.
module tb_par_ser_tx;

   logic       clk_32f = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       valid_in = 1'b0;

   logic load_req0, data_ack0, data_out0, active0;
   logic load_req1, data_ack1, data_out1, active1;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic lr;
      logic ack;
      logic act;
      logic dout;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   // Reference model state per instance: slot counting by cycles since reset.
   int         cyc[2]   = '{0, 0};
   int         loads[2] = '{0, 0};
   int         pos[2]   = '{8, 8};
   int         bcmin[2] = '{4, 1};
   logic [7:0] cur[2]   = '{8'h00, 8'h00};
   logic       dout[2]  = '{1'b0, 1'b0};

   always #5 clk_32f = ~clk_32f;

   par_ser_tx #(.BC_MIN(4)) u_dut0 (
      .clk_32f (clk_32f),
      .reset   (reset),
      .data_in (data_in),
      .valid_in(valid_in),
      .load_req(load_req0),
      .data_ack(data_ack0),
      .data_out(data_out0),
      .active  (active0)
   );

   par_ser_tx #(.BC_MIN(1)) u_dut1 (
      .clk_32f (clk_32f),
      .reset   (reset),
      .data_in (data_in),
      .valid_in(valid_in),
      .load_req(load_req1),
      .data_ack(data_ack1),
      .data_out(data_out1),
      .active  (active1)
   );

   function automatic void model(input int i, input logic r, input logic v,
                                 input logic [7:0] d, output exp_t e);
      bit is_load;
      bit trained;
      e.dout = dout[i];
      if (!r) begin
         e.lr = 1'b0; e.ack = 1'b0; e.act = 1'b0;
         dout[i] = 1'b0; cyc[i] = 0; loads[i] = 0; pos[i] = 8;
      end else begin
         is_load = (cyc[i] % 8 == 0);
         trained = (loads[i] >= bcmin[i]);
         e.lr  = is_load;
         e.act = trained;
         e.ack = is_load && trained && v;
         if (is_load) begin
            cur[i]   = (trained && v) ? d : 8'hBC;
            pos[i]   = 0;
            loads[i] = loads[i] + 1;
         end
         dout[i] = cur[i][7 - pos[i]];
         pos[i]  = pos[i] + 1;
         cyc[i]  = cyc[i] + 1;
      end
   endfunction

   task automatic step(input logic r, input logic v, input logic [7:0] d);
      exp_t e0;
      exp_t e1;
      @(negedge clk_32f);
      reset    = r;
      valid_in = v;
      data_in  = d;
      model(0, r, v, d, e0);
      model(1, r, v, d, e1);
      q0.push_back(e0);
      q1.push_back(e1);
   endtask

   task automatic check(input string name, input logic got, input logic want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s got=%b want=%b at %0t", name, got, want, $time);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk_32f);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check("bc4_load_req", load_req0, e.lr);
            check("bc4_data_ack", data_ack0, e.ack);
            check("bc4_active",   active0,   e.act);
            check("bc4_data_out", data_out0, e.dout);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check("bc1_load_req", load_req1, e.lr);
            check("bc1_data_ack", data_ack1, e.ack);
            check("bc1_active",   active1,   e.act);
            check("bc1_data_out", data_out1, e.dout);
         end
      end
   end

   task automatic send_byte(input logic v, input logic [7:0] d);
      for (int k = 0; k < 8; k++) step(1'b1, v, d);
   endtask

   initial begin
      // Long reset, then idle training and commas
      for (int k = 0; k < 16; k++) step(1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 8'h00);
      // Valid held through training: ignored until trained
      for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 48; k++) step(1'b1, 1'b1, 8'hA5);
      // Back-to-back bytes then idle
      send_byte(1'b1, 8'hFF);
      send_byte(1'b1, 8'h38);
      send_byte(1'b1, 8'hE0);
      for (int k = 0; k < 3; k++) send_byte(1'b0, 8'h00);
      // Data equal to the comma goes out verbatim
      send_byte(1'b1, 8'hBC);
      send_byte(1'b0, 8'h00);
      // Reset pulse after 3 bits of a byte
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 8'h0F);
      step(1'b0, 1'b1, 8'h0F);
      for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 8'h00);
      // Randomized traffic with occasional reset
      for (int k = 0; k < 600; k++)
         step(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);
      @(negedge clk_32f);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/par_ser_tx.md
Name: par_ser_tx

Overview:
Parallel-to-serial transmitter. It is the transmit end of the 8-bit serial link whose receiver checks for BC commas before going active. The block runs on clk_32f and converts each 8-bit byte to 8 serial bits, MSB first. It first sends a training run of BC commas so the far-end receiver can align and go active. After that it sends user bytes, and fills every idle slot with a BC comma.

Parameters:
BC_MIN, 4, number of consecutive commas sent after reset before user data is accepted (range 1..15)
COMMA, 8'hBC, idle/alignment character

Ports:
clk_32f  input  1  bit clock; the only clock; one serial bit per cycle
reset  input  1  synchronous reset, active-low; sampled on posedge clk_32f
data_in  input  8  parallel byte to send
valid_in  input  1  data_in holds a byte to send; sampled only on load edges
load_req  output  1  high in the cycle whose closing edge is a load edge; upstream presents data_in/valid_in here
data_ack  output  1  load_req & active & valid_in; the byte is consumed at this edge
data_out  output  1  serial output, registered
active  output  1  high once the training run is done (state ACTIVE)

Behaviour:
- Interface: one clock, clk_32f. reset is synchronous and active-low.
- Reset values (reset=0 at posedge):
  - bit_cnt=3'd7, shreg=8'h00, data_out=0, state=SYNC, bc_cnt=0.
  - load_req=0, data_ack=0, active=0. Combinational outputs are gated by reset.
- Bit counter:
  - bit_cnt increments mod 8 on every edge with reset=1.
  - A load edge is an edge where bit_cnt==7.
  - The first edge after reset is released is a load edge.
- Load edge:
  - Byte selection: byte = (state==ACTIVE && valid_in) ? data_in : COMMA.
  - Updates: data_out<=byte[7]; shreg<={byte[6:0],1'b0}.
- Non-load edge: data_out<=shreg[7]; shreg<=shreg<<1.
- Latency: a byte sampled at load edge E appears on data_out as bit7 after E, then bit6..bit0 on the next 7 cycles. This is exactly 8 cycles per byte with no gaps. A new byte is loaded at E+8.
- Output timing: load_req=(bit_cnt==7), asserted every 8th cycle.
- State machine (updates only on load edges):
  - SYNC: always sends COMMA; valid_in is ignored and no ack is given. bc_cnt increments on each load edge. At the load edge where bc_cnt==BC_MIN-1, go to ACTIVE and clear bc_cnt. Exactly BC_MIN commas are sent.
  - ACTIVE: sends data_in when valid_in=1, otherwise COMMA. There is no exit except reset.
- active is a registered state decode. It rises after the load edge that starts the last training comma. The first user byte can therefore be taken at load edge number BC_MIN+1 after reset.
- Back-to-back bytes: valid_in held high gives continuous data with no interleaved commas.
- valid_in/data_in on non-load edges: don't-care. They have no effect and there is no ack.
- Data equal to 8'hBC is sent verbatim. No escaping is done; framing is the receiver's concern.
- Reset mid-byte or mid-training: the partial byte is abandoned. data_out goes to 0 at the reset edge and training restarts from bc_cnt=0.
- Reset held low: data_out stays 0 and load_req stays 0.

Decomposition:
- Shared package ser_par_pkg holds:
  - localparam COMMA_BC=8'hBC, used as the default for COMMA and by the receiver.
  - State encoding typedef {SYNC=1'b0, ACTIVE=1'b1}.
  - localparam BITS_PER_BYTE=8.
- No sub-module is needed. The bit counter, shifter and 2-state FSM stay in one module of about 150 lines.

Test Plan:
- Reset held low for 16 cycles, then released; valid_in=0 -> data_out 0 during reset. Starting the cycle after the first post-reset edge, the stream is 10111100 repeated 4 times. active rises when the 4th comma starts. load_req pulses every 8 cycles.
- valid_in=1 with data_in=8'hA5 throughout training -> no data_ack during SYNC. The first data_ack is at load edge 5, after which data_out=1,0,1,0,0,1,0,1.
- ACTIVE with valid_in=1 for 8'hFF, 8'h38, 8'hE0, then valid_in=0 -> serial 11111111 00111000 11100000, then 10111100 repeated. data_ack fires 3 times.
- ACTIVE with data_in=8'hBC, valid_in=1 -> sends 10111100 and data_ack=1; the stream is identical to idle.
- reset=0 pulsed for 1 cycle in the middle of a data byte (after 3 bits of 8'h0F) -> data_out=0 at the next edge. 4 fresh commas follow and active drops, then re-asserts.
- BC_MIN=1 override -> one comma after reset. data_ack is possible on the 2nd load edge and active is high after the 1st load edge.
